// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM state encoding, clog2 helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Number of bits needed to count 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver output bus: payload, per-frame error flags, sticky overrun with clear, busy indication.
// Latency: n/a (wires only).
// Backpressure: data_out_valid holds until data_out_ready is seen; master drives payload, slave drives ready/clear.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 err_clear;
    logic                 busy;

    modport master (
        output data_out,
        output data_out_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        output busy,
        input  data_out_ready,
        input  err_clear
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        input  busy,
        output data_out_ready,
        output err_clear
    );

endinterface

// File: rtl/uart_bit_sampler.sv
// RX line front end: 2-flop synchroniser, mid-bit counter, sample strobe; optional 2-of-3 vote (UART_RX_MAJORITY_EN).
// Latency: 2 cycles line-to-line_o; strobe SAMPLE_TIME (half) or SYMBOL_EDGE_TIME (full) cycles after the last clear/strobe.
// Backpressure: none; the FSM must act on sample_strobe in the cycle it is high.
// Ports: clk/rst, serial_in (async raw line), cnt_clr_i (hold counter at 0), half_i (use half-bit target),
//        line_o (synchronised line), sample_strobe, sample_value.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 434,
    parameter int SAMPLE_TIME      = 217,
    parameter int CNT_W            = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic cnt_clr_i,
    input  logic half_i,
    output logic line_o,
    output logic sample_strobe,
    output logic sample_value
);

    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(SAMPLE_TIME - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign line_o        = sync2_q;
    assign sample_strobe = (cnt_q == (half_i ? LAST_HALF : LAST_FULL));

    // The counter restarts on every strobe so consecutive bits stay one symbol apart.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_clr_i || sample_strobe) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Vote over the current and two previous synchronised samples; the decision
    // cycle is unchanged, the vote window is simply centred one cycle earlier.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    assign sample_value = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_value = sync2_q;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (data width, parity, stop bits, glitch reject, break, sticky overrun); macro UART_RX_MAJORITY_EN.
// Latency: payload valid 1 cycle after the last stop-bit sample (plus 2-cycle line synchroniser).
// Backpressure: valid holds until ready; a frame completing while valid is held is dropped and sets sticky overrun_err.
// Ports: clk, rst (async active-high), serial_in (raw line, idle high), rx (master modport: data_out,
//        data_out_valid, data_out_ready, parity_err, frame_err, overrun_err, err_clear, busy).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    uart_rx_param_if.master   rx
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = (clog2(SYMBOL_EDGE_TIME) < 1) ? 1 : clog2(SYMBOL_EDGE_TIME);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 commit_q, commit_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 ovr_set;

    logic                 cnt_clr;
    logic                 half_sel;
    logic                 line;
    logic                 sample_strobe;
    logic                 sample_value;

    uart_bit_sampler #(
        .SYMBOL_EDGE_TIME (SYMBOL_EDGE_TIME),
        .SAMPLE_TIME      (SAMPLE_TIME),
        .CNT_W            (CNT_W)
    ) u_sampler (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .cnt_clr_i     (cnt_clr),
        .half_i        (half_sel),
        .line_o        (line),
        .sample_strobe (sample_strobe),
        .sample_value  (sample_value)
    );

    // Frame FSM. State names are qualified because PARITY is also a module parameter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        commit_d  = 1'b0;
        cnt_clr   = 1'b0;
        half_sel  = 1'b0;

        case (state_q)
            uart_pkg::IDLE: begin
                cnt_clr = 1'b1;
                if (!line) begin
                    state_d = uart_pkg::START;
                end
            end

            uart_pkg::START: begin
                half_sel = 1'b1;
                if (sample_strobe) begin
                    if (sample_value) begin
                        state_d = uart_pkg::IDLE;   // start bit did not survive to mid-bit
                    end else begin
                        state_d   = uart_pkg::DATA;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
            end

            uart_pkg::DATA: begin
                if (sample_strobe) begin
                    shift_d = {sample_value, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : uart_pkg::STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            uart_pkg::PARITY: begin
                if (sample_strobe) begin
                    perr_d  = (PARITY == PARITY_ODD) ? ~(^shift_q ^ sample_value)
                                                     :  (^shift_q ^ sample_value);
                    state_d = uart_pkg::STOP;
                end
            end

            uart_pkg::STOP: begin
                if (sample_strobe) begin
                    ferr_d = ferr_q | ~sample_value;
                    if (bit_cnt_q == LAST_STOP) begin
                        commit_d = 1'b1;
                        // All-zero payload with a low stop bit is a break: wait for the line to recover.
                        state_d  = (ferr_d && (shift_q == '0)) ? uart_pkg::BREAK : uart_pkg::IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            uart_pkg::BREAK: begin
                cnt_clr = 1'b1;
                if (line) begin
                    state_d = uart_pkg::IDLE;
                end
            end

            default: begin
                state_d = uart_pkg::IDLE;
            end
        endcase
    end

    // Output holding register. A commit in the same cycle as an accept replaces the held frame.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_set    = 1'b0;

        if (valid_q && rx.data_out_ready) begin
            valid_d = 1'b0;
        end

        if (commit_q) begin
            if (!valid_q || rx.data_out_ready) begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
                valid_d    = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        // Set has priority over a coincident clear.
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (rx.err_clear) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= uart_pkg::IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            commit_q   <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            commit_q   <= commit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx.data_out       = data_q;
    assign rx.data_out_valid = valid_q;
    assign rx.parity_err     = perr_out_q;
    assign rx.frame_err      = ferr_out_q;
    assign rx.overrun_err    = ovr_q;
    assign rx.busy           = (state_q != uart_pkg::IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 default rate, 7E1 and 8N2 fast-rate instances.
// Latency: n/a.
// Backpressure: ready driven per step; accepted frames are captured on the falling edge.
module tb_uart_rx_param;

    localparam int CPB0 = 434;   // 50 MHz / 115200
    localparam int CPBF = 16;    // 1.6 MHz / 100 kbaud

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin0 = 1'b1;
    logic sin1 = 1'b1;
    logic sin2 = 1'b1;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(7)) if1 ();
    uart_rx_param_if #(.DATA_BITS(8)) if2 ();

    uart_rx_param u0 (.clk(clk), .rst(rst), .serial_in(sin0), .rx(if0));

    uart_rx_param #(
        .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
    ) u1 (.clk(clk), .rst(rst), .serial_in(sin1), .rx(if1));

    uart_rx_param #(
        .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)
    ) u2 (.clk(clk), .rst(rst), .serial_in(sin2), .rx(if2));

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } cap_t;

    cap_t q0[$];
    cap_t q1[$];
    cap_t q2[$];

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        if (if0.data_out_valid && if0.data_out_ready)
            q0.push_back({1'b0, if0.data_out, if0.parity_err, if0.frame_err});
        if (if1.data_out_valid && if1.data_out_ready)
            q1.push_back({2'b00, if1.data_out, if1.parity_err, if1.frame_err});
        if (if2.data_out_valid && if2.data_out_ready)
            q2.push_back({1'b0, if2.data_out, if2.parity_err, if2.frame_err});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic v);
        case (ch)
            0:       sin0 = v;
            1:       sin1 = v;
            default: sin2 = v;
        endcase
    endtask

    // Bits go out LSB first, each held for cpb cycles; called just after a rising edge.
    task automatic send_bits(input int ch, input logic [15:0] bits, input int n, input int cpb);
        for (int i = 0; i < n; i++) begin
            drive(ch, bits[i]);
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;

        if0.data_out_ready = 1'b1;
        if0.err_clear      = 1'b0;
        if1.data_out_ready = 1'b1;
        if1.err_clear      = 1'b0;
        if2.data_out_ready = 1'b1;
        if2.err_clear      = 1'b0;

        // Reset state
        wait_cyc(3);
        check("rst_data",  32'(if0.data_out), 32'h0);
        check("rst_valid", 32'(if0.data_out_valid), 32'h0);
        check("rst_perr",  32'(if0.parity_err), 32'h0);
        check("rst_ferr",  32'(if0.frame_err), 32'h0);
        check("rst_ovr",   32'(if0.overrun_err), 32'h0);
        check("rst_busy",  32'(if0.busy), 32'h0);
        rst = 1'b0;
        wait_cyc(5);

        // 8N1 back-to-back 0x61..0x6A at 434 cycles per bit
        for (int k = 0; k < 10; k++) begin
            b = 8'h61 + 8'(k);
            send_bits(0, {6'b0, 1'b1, b, 1'b0}, 10, CPB0);
        end
        wait_cyc(40);
        check("b2b_count", 32'(q0.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            check("b2b_data", 32'(q0[k].d), 32'h61 + 32'(k));
            check("b2b_errs", 32'({q0[k].pe, q0[k].fe}), 32'h0);
        end

        // 100-cycle glitch: 2 sync + 1 detect + 217 START cycles -> IDLE after edge 220
        drive(0, 1'b0);
        wait_cyc(100);
        drive(0, 1'b1);
        wait_cyc(50);
        check("glitch_busy_mid", 32'(if0.busy), 32'h1);
        wait_cyc(71);
        check("glitch_busy_end", 32'(if0.busy), 32'h0);
        check("glitch_noframe", 32'(q0.size()), 32'd10);

        // 7E1: 0x41 has two ones, so even parity bit 0 is correct and 1 is wrong
        send_bits(1, {6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, CPBF);
        send_bits(1, {6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, CPBF);
        wait_cyc(40);
        check("par_count", 32'(q1.size()), 32'd2);
        check("par_d0",    32'(q1[0].d), 32'h41);
        check("par_pe0",   32'(q1[0].pe), 32'h0);
        check("par_fe0",   32'(q1[0].fe), 32'h0);
        check("par_d1",    32'(q1[1].d), 32'h41);
        check("par_pe1",   32'(q1[1].pe), 32'h1);

        // 8N2 with second stop bit low
        send_bits(2, {5'b0, 1'b0, 1'b1, 8'hA5, 1'b0}, 11, CPBF);
        drive(2, 1'b1);
        wait_cyc(48);
        check("stop2_count", 32'(q2.size()), 32'd1);
        check("stop2_data",  32'(q2[0].d), 32'hA5);
        check("stop2_ferr",  32'(q2[0].fe), 32'h1);
        q2.delete();

        // Overrun: ready low while two frames arrive
        if2.data_out_ready = 1'b0;
        send_bits(2, {5'b0, 2'b11, 8'h11, 1'b0}, 11, CPBF);
        send_bits(2, {5'b0, 2'b11, 8'h22, 1'b0}, 11, CPBF);
        wait_cyc(32);
        check("ovr_valid", 32'(if2.data_out_valid), 32'h1);
        check("ovr_data",  32'(if2.data_out), 32'h11);
        check("ovr_flag",  32'(if2.overrun_err), 32'h1);
        if2.data_out_ready = 1'b1;
        wait_cyc(1);
        if2.data_out_ready = 1'b0;
        check("ovr_valid_drop", 32'(if2.data_out_valid), 32'h0);
        check("ovr_accepted",   32'(q2.size()), 32'd1);
        check("ovr_sticky",     32'(if2.overrun_err), 32'h1);
        if2.err_clear = 1'b1;
        wait_cyc(1);
        if2.err_clear = 1'b0;
        check("ovr_cleared", 32'(if2.overrun_err), 32'h0);
        q2.delete();
        if2.data_out_ready = 1'b1;
        wait_cyc(4);

        // Break: line low for 20 bit times
        drive(2, 1'b0);
        wait_cyc(200);
        check("brk_busy",   32'(if2.busy), 32'h1);
        check("brk_count1", 32'(q2.size()), 32'd1);
        wait_cyc(120);
        check("brk_count2", 32'(q2.size()), 32'd1);
        drive(2, 1'b1);
        wait_cyc(32);
        check("brk_idle", 32'(if2.busy), 32'h0);
        check("brk_data", 32'(q2[0].d), 32'h00);
        check("brk_ferr", 32'(q2[0].fe), 32'h1);
        q2.delete();

        // Reset in the middle of DATA of 0x5A, then a clean 0x3C
        send_bits(2, {5'b0, 2'b11, 8'h5A, 1'b0}, 4, CPBF);
        check("mid_busy", 32'(if2.busy), 32'h1);
        rst = 1'b1;
        drive(2, 1'b1);
        wait_cyc(3);
        check("mid_rst_busy",  32'(if2.busy), 32'h0);
        check("mid_rst_valid", 32'(if2.data_out_valid), 32'h0);
        rst = 1'b0;
        wait_cyc(48);
        check("mid_noframe", 32'(q2.size()), 32'd0);
        send_bits(2, {5'b0, 2'b11, 8'h3C, 1'b0}, 11, CPBF);
        wait_cyc(32);
        check("post_count", 32'(q2.size()), 32'd1);
        check("post_data",  32'(q2[0].d), 32'h3C);
        check("post_ferr",  32'(q2[0].fe), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
